// File: rtl/imem_loader.sv
// imem_loader: writable instruction memory with a byte-stream boot loader.
// After reset the array is zero-cleared, then a program arrives as
// <count byte> followed by count words sent MSB-first, one byte per transfer.
// The CPU is held (cpu_hold) until the whole program has been written.
module imem_loader #(
  parameter int N     = 32,
  parameter int DEPTH = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  output logic                     rx_ready,
  input  logic                     reload,
  input  logic [$clog2(DEPTH)-1:0] addr,
  output logic [N-1:0]             q,
  output logic                     cpu_hold,
  output logic                     load_done,
  output logic [7:0]               word_cnt
);

  localparam int BPW = N / 8;
  localparam int AW  = $clog2(DEPTH);
  localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_HDR   = 2'd1,
    S_LOAD  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  clr_ptr_q, clr_ptr_d;
  // One extra bit so the pointer can sit at DEPTH after the last word
  // without aliasing back onto address 0.
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [BIW-1:0] byte_idx_q, byte_idx_d;
  logic [7:0]     word_cnt_q, word_cnt_d;
  logic [7:0]     cnt_c_q, cnt_c_d;
  // Only the low N-8 bits of the assembly register are ever needed: the
  // byte arriving on the final transfer supplies the bottom 8 bits directly.
  logic [N-9:0]   sh_q, sh_d;
  logic           rx_ready_q, rx_ready_d;
  logic           cpu_hold_q, cpu_hold_d;
  logic           load_done_q, load_done_d;

  logic           xfer;
  logic [N-1:0]   sh_full;
  logic           mem_we;
  logic [AW-1:0]  mem_waddr;
  logic [N-1:0]   mem_wdata;

  logic [N-1:0]   mem [DEPTH];

  assign xfer    = rx_valid & rx_ready_q;
  assign sh_full = {sh_q, rx_data};

  // Next-state, datapath updates and memory write request for the loader FSM.
  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    byte_idx_d  = byte_idx_q;
    word_cnt_d  = word_cnt_q;
    cnt_c_d     = cnt_c_q;
    sh_d        = sh_q;
    mem_we      = 1'b0;
    mem_waddr   = {AW{1'b0}};
    mem_wdata   = {N{1'b0}};

    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        if (clr_ptr_q == AW'(DEPTH - 1)) begin
          state_d = S_HDR;
        end else begin
          clr_ptr_d = clr_ptr_q + AW'(1);
        end
      end
      S_HDR: begin
        if (xfer) begin
          // A zero count means a full image; oversize counts are clamped.
          if ((rx_data == 8'd0) || (rx_data > 8'(DEPTH))) begin
            cnt_c_d = 8'(DEPTH);
          end else begin
            cnt_c_d = rx_data;
          end
          wr_ptr_d   = {(AW + 1){1'b0}};
          byte_idx_d = {BIW{1'b0}};
          word_cnt_d = 8'd0;
          state_d    = S_LOAD;
        end else begin
          state_d = S_HDR;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          sh_d = sh_full[N-9:0];
          if (byte_idx_q == BIW'(BPW - 1)) begin
            mem_we     = 1'b1;
            mem_waddr  = wr_ptr_q[AW-1:0];
            mem_wdata  = sh_full;
            wr_ptr_d   = wr_ptr_q + (AW + 1)'(1);
            word_cnt_d = word_cnt_q + 8'd1;
            byte_idx_d = {BIW{1'b0}};
            if ((word_cnt_q + 8'd1) == cnt_c_q) begin
              state_d = S_DONE;
            end else begin
              state_d = S_LOAD;
            end
          end else begin
            byte_idx_d = byte_idx_q + BIW'(1);
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        if (reload) begin
          state_d   = S_CLEAR;
          clr_ptr_d = {AW{1'b0}};
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d   = S_CLEAR;
        clr_ptr_d = {AW{1'b0}};
      end
    endcase

    // Handshake and status outputs are decoded from the next state so the
    // registered versions line up with the state they describe.
    rx_ready_d  = (state_d == S_HDR) || (state_d == S_LOAD);
    cpu_hold_d  = (state_d != S_DONE);
    load_done_d = (state_d == S_DONE);
  end

  // Loader FSM state, pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_CLEAR;
      clr_ptr_q   <= {AW{1'b0}};
      wr_ptr_q    <= {(AW + 1){1'b0}};
      byte_idx_q  <= {BIW{1'b0}};
      word_cnt_q  <= 8'd0;
      cnt_c_q     <= 8'd0;
      sh_q        <= {(N - 8){1'b0}};
      rx_ready_q  <= 1'b0;
      cpu_hold_q  <= 1'b1;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      byte_idx_q  <= byte_idx_d;
      word_cnt_q  <= word_cnt_d;
      cnt_c_q     <= cnt_c_d;
      sh_q        <= sh_d;
      rx_ready_q  <= rx_ready_d;
      cpu_hold_q  <= cpu_hold_d;
      load_done_q <= load_done_d;
    end
  end

  // Memory array write port; never reset, the CLEAR sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign q         = mem[addr];
  assign rx_ready  = rx_ready_q;
  assign cpu_hold  = cpu_hold_q;
  assign load_done = load_done_q;
  assign word_cnt  = word_cnt_q;

endmodule
